act_mem_arb: RTL and testbench
==============================

// Module: act_mem_arb
// PURPOSE
//  Write-side arbiter/sequencer for the two activation memory banks.
//  - In IDLE, admits host BRAM-controller writes: ECG samples go into bank0/bank1.
//  - After LOADWORDS accepted words, pulses ecg_rd_done to start ctrl_pe.
//  - In RUN, hands the write port to pooling; host writes are dropped and flagged.
//  - Sits between the BRAM-ctrl port / pooling and act_unimem write inputs.
// PARAMETERS
//  ACTMEMADRWID  11   word address width of each activation bank
//  BRAMADRWID    15   host byte-address width
//  LOADWORDS     640  host words to accept before start; range 1..4095
// PORTS
//  clk           in   1     system clock, rising edge
//  rst_n         in   1     asynchronous active-low reset
//  bram_addr_a   in   15    host byte address
//  bram_wrdata_a in   32    host write data
//  bram_en_a     in   1     host access enable
//  bram_we_a     in   1     host write strobe; a host write is bram_en_a & bram_we_a
//  pwr0ena       in   1     pooling write enable, bank0
//  pwr1ena       in   1     pooling write enable, bank1
//  pwr0addr      in   11    pooling address, bank0
//  pwr1addr      in   11    pooling address, bank1
//  pwrdata       in   32    pooling write data, shared by both banks
//  infer_done    in   1     classification finished (pe_cs==DONE)
//  wactmem0ena   out  1     bank0 enable to act_unimem
//  wactmem1ena   out  1     bank1 enable to act_unimem
//  wactmem0wea   out  1     bank0 write enable to act_unimem
//  wactmem1wea   out  1     bank1 write enable to act_unimem
//  wactmem0addr  out  11    bank0 address to act_unimem
//  wactmem1addr  out  11    bank1 address to act_unimem
//  wactmemdata   out  32    write data to act_unimem
//  ecg_rd_done   out  1     one-cycle start pulse
//  state         out  2     00 IDLE, 01 RUN, 10 DONE
//  load_cnt      out  12    host words accepted since entering IDLE
//  host_drop     out  1     sticky: a host write was refused
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, load_cnt=0. Reset is asynchronous;
//   reset mid-load or mid-run aborts with no further memory writes.
//  Latency: all memory outputs are registered, 1 cycle after the input.
//   ena and wea are 0 in any cycle without a granted write.
//  Host address decode:
//   - word = addr[14:2]; bank = addr[13]; local address = addr[12:2].
//   - addr[14]=1 -> out of range: write refused, host_drop set.
//   - addr[1:0] is ignored.
//  IDLE:
//   - A valid host write drives bank[bank] ena=wea=1, address=local, data=wrdata.
//   - load_cnt increments, saturating at 4095.
//   - Repeat addresses are counted again.
//   - Pooling enables are ignored.
//   - When the accepted write makes load_cnt==LOADWORDS: ecg_rd_done=1 in the
//     same cycle as that memory write; state->RUN next cycle.
//  RUN:
//   - Pooling enables pass through. Both banks may be written in the same cycle
//     with the shared pwrdata.
//   - Host writes are refused and set host_drop.
//   - infer_done=1 -> DONE next cycle.
//  DONE:
//   - No pooling writes.
//   - The first valid host write is performed and counted as word 1.
//     In that cycle state->IDLE, load_cnt=1, host_drop is cleared.
//  Host write and pooling write in the same cycle: the state decides the owner
//   (IDLE=host, RUN=pool). Never both, and neither is buffered.
//  Host reads (bram_we_a=0) are ignored in every state.
//  LOADWORDS=1: the first write pulses ecg_rd_done immediately.
// TESTING
//  1. Reset, then 640 host writes to byte addr 0x0000..0x09FC (bank0 0..639)
//     -> 640 bank0 writes with matching addr/data; ecg_rd_done=1 exactly once,
//     on write 640; state=01.
//  2. IDLE, host write addr 0x2004, data 0xA5A5A5A5 -> next cycle wactmem1ena=wea=1,
//     wactmem1addr=1, bank0 idle. Host write addr 0x4000 -> no memory write,
//     host_drop=1.
//  3. RUN, pwr0ena=pwr1ena=1, addr 5/7, data 0x12345678, plus a host write in the
//     same cycle -> both banks written with pool data; host write dropped;
//     host_drop=1.
//  4. RUN -> infer_done -> DONE; pool enable is then ignored. Host write to
//     0x0000 -> performed, state=IDLE, load_cnt=1, host_drop=0.
//  5. Assert rst_n=0 at load_cnt=300 -> all outputs 0 asynchronously. After
//     release, 640 further writes are needed for ecg_rd_done.

Source files
------------

// File: rtl/act_mem_arb.sv
// Write-side arbiter for the two activation banks: host loads ECG words in IDLE,
// pooling owns the write port in RUN, and the first host write after DONE reopens loading.
module act_mem_arb #(
  parameter int unsigned ACTMEMADRWID = 11,
  parameter int unsigned BRAMADRWID   = 15,
  parameter int unsigned LOADWORDS    = 640
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BRAMADRWID-1:0]   bram_addr_a,
  input  logic [31:0]             bram_wrdata_a,
  input  logic                    bram_en_a,
  input  logic                    bram_we_a,
  input  logic                    pwr0ena,
  input  logic                    pwr1ena,
  input  logic [ACTMEMADRWID-1:0] pwr0addr,
  input  logic [ACTMEMADRWID-1:0] pwr1addr,
  input  logic [31:0]             pwrdata,
  input  logic                    infer_done,
  output logic                    wactmem0ena,
  output logic                    wactmem1ena,
  output logic                    wactmem0wea,
  output logic                    wactmem1wea,
  output logic [ACTMEMADRWID-1:0] wactmem0addr,
  output logic [ACTMEMADRWID-1:0] wactmem1addr,
  output logic [31:0]             wactmemdata,
  output logic                    ecg_rd_done,
  output logic [1:0]              state,
  output logic [11:0]             load_cnt,
  output logic                    host_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [11:0] LOAD_TARGET = 12'(LOADWORDS);
  localparam logic [11:0] CNT_MAX     = '1;

  state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic        drop_q, drop_d;
  logic        start_d;
  logic        host_wr, in_range, host_bank;
  logic        host_ok, pool_ok;
  logic        ena0_d, ena1_d;
  logic [ACTMEMADRWID-1:0] local_addr;
  logic        unused_low_bits;

  assign host_wr    = bram_en_a & bram_we_a;
  assign in_range   = ~bram_addr_a[BRAMADRWID-1];
  assign host_bank  = bram_addr_a[ACTMEMADRWID+2];
  assign local_addr = bram_addr_a[ACTMEMADRWID+1:2];
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 12'd1;
  assign unused_low_bits = ^bram_addr_a[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    start_d = 1'b0;
    host_ok = 1'b0;
    pool_ok = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (host_wr) begin
          if (in_range) begin
            host_ok = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc == LOAD_TARGET) begin
              start_d = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        pool_ok = 1'b1;
        if (host_wr) drop_d = 1'b1;
        if (infer_done) state_d = S_DONE;
      end
      S_DONE: begin
        // The reopening write is itself the first word of the next load.
        if (host_wr) begin
          if (in_range) begin
            host_ok = 1'b1;
            cnt_d   = 12'd1;
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ena0_d = (host_ok & ~host_bank) | (pool_ok & pwr0ena);
  assign ena1_d = (host_ok &  host_bank) | (pool_ok & pwr1ena);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wactmem0ena  <= 1'b0;
      wactmem1ena  <= 1'b0;
      wactmem0wea  <= 1'b0;
      wactmem1wea  <= 1'b0;
      wactmem0addr <= '0;
      wactmem1addr <= '0;
      wactmemdata  <= '0;
      ecg_rd_done  <= 1'b0;
    end else begin
      wactmem0ena <= ena0_d;
      wactmem1ena <= ena1_d;
      wactmem0wea <= ena0_d;
      wactmem1wea <= ena1_d;
      ecg_rd_done <= start_d;
      if (ena0_d) wactmem0addr <= host_ok ? local_addr : pwr0addr;
      if (ena1_d) wactmem1addr <= host_ok ? local_addr : pwr1addr;
      if (ena0_d | ena1_d) wactmemdata <= host_ok ? bram_wrdata_a : pwrdata;
    end
  end

  assign state     = state_q;
  assign load_cnt  = cnt_q;
  assign host_drop = drop_q;

endmodule

// File: tb/tb_act_mem_arb.sv
// Randomized bench for act_mem_arb against a cycle-level behavioural model.
module tb_act_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] bram_addr_a = '0;
  logic [31:0] bram_wrdata_a = '0;
  logic        bram_en_a = 1'b0, bram_we_a = 1'b0;
  logic        pwr0ena = 1'b0, pwr1ena = 1'b0;
  logic [10:0] pwr0addr = '0, pwr1addr = '0;
  logic [31:0] pwrdata = '0;
  logic        infer_done = 1'b0;
  logic        wactmem0ena, wactmem1ena, wactmem0wea, wactmem1wea;
  logic [10:0] wactmem0addr, wactmem1addr;
  logic [31:0] wactmemdata;
  logic        ecg_rd_done;
  logic [1:0]  state;
  logic [11:0] load_cnt;
  logic        host_drop;

  act_mem_arb #(.ACTMEMADRWID(11), .BRAMADRWID(15), .LOADWORDS(640)) dut (
    .clk(clk), .rst_n(rst_n),
    .bram_addr_a(bram_addr_a), .bram_wrdata_a(bram_wrdata_a),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a),
    .pwr0ena(pwr0ena), .pwr1ena(pwr1ena),
    .pwr0addr(pwr0addr), .pwr1addr(pwr1addr), .pwrdata(pwrdata),
    .infer_done(infer_done),
    .wactmem0ena(wactmem0ena), .wactmem1ena(wactmem1ena),
    .wactmem0wea(wactmem0wea), .wactmem1wea(wactmem1wea),
    .wactmem0addr(wactmem0addr), .wactmem1addr(wactmem1addr),
    .wactmemdata(wactmemdata), .ecg_rd_done(ecg_rd_done),
    .state(state), .load_cnt(load_cnt), .host_drop(host_drop)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_pulse = 0;

  // Model: phase 0 loading, 1 pooling, 2 finished
  int          m_phase = 0;
  int          m_cnt   = 0;
  bit          m_drop  = 0;
  bit          e_ena0, e_ena1, e_done;
  logic [10:0] e_a0, e_a1;
  logic [31:0] e_d;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit hw;
    int word;
    hw = bram_en_a && bram_we_a;
    word = int'(bram_addr_a) / 4;
    e_ena0 = 0; e_ena1 = 0; e_done = 0;
    e_a0 = 'x; e_a1 = 'x; e_d = 'x;
    if (m_phase == 1) begin
      e_ena0 = pwr0ena; e_ena1 = pwr1ena;
      e_a0 = pwr0addr; e_a1 = pwr1addr; e_d = pwrdata;
      if (hw) m_drop = 1;
      if (infer_done) m_phase = 2;
    end else if (hw) begin
      if (word >= 4096) m_drop = 1;
      else begin
        if (word >= 2048) begin e_ena1 = 1; e_a1 = 11'(word - 2048); end
        else begin e_ena0 = 1; e_a0 = 11'(word); end
        e_d = bram_wrdata_a;
        if (m_phase == 2) begin
          m_phase = 0; m_cnt = 1; m_drop = 0;
        end else begin
          m_cnt = (m_cnt < 4095) ? m_cnt + 1 : 4095;
          if (m_cnt == 640) begin e_done = 1; m_phase = 1; end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (ecg_rd_done === 1'b1) n_pulse++;
    check("ena0", wactmem0ena, e_ena0);
    check("wea0", wactmem0wea, e_ena0);
    check("ena1", wactmem1ena, e_ena1);
    check("wea1", wactmem1wea, e_ena1);
    if (e_ena0) check("addr0", wactmem0addr, e_a0);
    if (e_ena1) check("addr1", wactmem1addr, e_a1);
    if (e_ena0 || e_ena1) check("data", wactmemdata, e_d);
    check("rd_done", ecg_rd_done, e_done);
    check("state", state, m_phase);
    check("load_cnt", load_cnt, m_cnt);
    check("host_drop", host_drop, m_drop);
    @(negedge clk);
  endtask

  task automatic rand_inputs(input bit allow_infer);
    bram_en_a     = ($urandom % 4) != 0;
    bram_we_a     = ($urandom % 4) != 0;
    bram_addr_a   = {($urandom % 8) == 0, 14'($urandom)};
    bram_wrdata_a = $urandom;
    pwr0ena       = $urandom % 2;
    pwr1ena       = $urandom % 2;
    pwr0addr      = 11'($urandom);
    pwr1addr      = 11'($urandom);
    pwrdata       = $urandom;
    infer_done    = allow_infer && (($urandom % 16) == 0);
  endtask

  task automatic quiet();
    bram_en_a = 0; bram_we_a = 0; pwr0ena = 0; pwr1ena = 0; infer_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, {wactmem0ena, wactmem1ena, wactmem0wea, wactmem1wea}, 0);
    check({tag, "_addr"}, {wactmem0addr, wactmem1addr}, 0);
    check({tag, "_data"}, wactmemdata, 0);
    check({tag, "_ctl"}, {ecg_rd_done, state, host_drop}, 0);
    check({tag, "_cnt"}, load_cnt, 0);
  endtask

  initial begin
    int guard;
    quiet();
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Full bank0 load
    n_pulse = 0;
    for (int i = 0; i < 640; i++) begin
      rand_inputs(1'b0);
      bram_en_a = 1; bram_we_a = 1;
      bram_addr_a = 15'(i * 4);
      tick();
    end
    check("load_pulses", n_pulse, 1);
    check("load_state", state, 2'b01);

    // Pool owns both banks; concurrent host write is dropped
    quiet();
    pwr0ena = 1; pwr1ena = 1; pwr0addr = 11'd5; pwr1addr = 11'd7; pwrdata = 32'h12345678;
    bram_en_a = 1; bram_we_a = 1; bram_addr_a = 15'h0010; bram_wrdata_a = 32'hDEADBEEF;
    tick();
    check("run_drop", host_drop, 1);

    for (int i = 0; i < 60; i++) begin
      rand_inputs(1'b0);
      tick();
    end

    quiet();
    infer_done = 1;
    tick();
    quiet();
    pwr0ena = 1; pwr1ena = 1;
    tick();
    bram_en_a = 1; bram_we_a = 1; bram_addr_a = 15'h0000; bram_wrdata_a = 32'h0BADF00D;
    pwr0ena = 0; pwr1ena = 0;
    tick();
    check("reopen_state", state, 2'b00);
    check("reopen_cnt", load_cnt, 1);
    check("reopen_drop", host_drop, 0);

    // Bank1 decode, then out-of-range refusal
    quiet();
    bram_en_a = 1; bram_we_a = 1; bram_addr_a = 15'h2004; bram_wrdata_a = 32'hA5A5A5A5;
    tick();
    check("bank1_addr", wactmem1addr, 1);
    bram_addr_a = 15'h4000;
    tick();
    check("oor_drop", host_drop, 1);

    // Random loading up to 300 words, then asynchronous reset
    guard = 0;
    while (m_cnt < 300 && guard < 5000) begin
      rand_inputs(1'b1);
      tick();
      guard++;
    end
    check("reach_300", m_cnt, 300);
    quiet();
    #2;
    rst_n = 0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1;

    // Full reload needed after reset
    n_pulse = 0;
    guard = 0;
    while (m_phase == 0 && guard < 8000) begin
      rand_inputs(1'b1);
      tick();
      guard++;
    end
    check("reload_done", m_phase, 1);
    check("reload_pulses", n_pulse, 1);
    check("reload_cnt", load_cnt, 640);

    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
